// File: rtl/knap_pkg.sv
// Shared types, FSM encoding and per-item tables for the 13-item knapsack sweep.
package knap_pkg;

    localparam int NUM_ITEMS = 13;

    typedef logic [NUM_ITEMS-1:0] knap_mask_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2
    } knap_state_t;

    localparam knap_mask_t LAST_MASK = 13'h1FFF;

    // Index 0 is item A, which maps to mask bit 12.
    localparam logic [7:0] ITEM_VALUE [NUM_ITEMS] = '{
        8'd4, 8'd8, 8'd0, 8'd20, 8'd10, 8'd12, 8'd18, 8'd14, 8'd6, 8'd15, 8'd30, 8'd8, 8'd16
    };
    localparam logic [7:0] ITEM_WEIGHT [NUM_ITEMS] = '{
        8'd28, 8'd8, 8'd27, 8'd18, 8'd27, 8'd28, 8'd6, 8'd1, 8'd20, 8'd0, 8'd5, 8'd13, 8'd8
    };
    localparam logic [7:0] ITEM_VOLUME [NUM_ITEMS] = '{
        8'd27, 8'd27, 8'd4, 8'd4, 8'd0, 8'd24, 8'd4, 8'd20, 8'd12, 8'd15, 8'd5, 8'd2, 8'd9
    };

endpackage

// File: rtl/knap_totals.sv
// Combinational mask -> (value, weight, volume) totals over the item tables.
module knap_totals
    import knap_pkg::*;
(
    input  knap_mask_t  i_mask,
    output logic [7:0]  o_value,
    output logic [7:0]  o_weight,
    output logic [7:0]  o_volume
);

    // Table maxima (161/189/153) fit in 8 bits, so the sums never wrap.
    always_comb begin
        o_value  = '0;
        o_weight = '0;
        o_volume = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (i_mask[NUM_ITEMS-1-i]) begin
                o_value  = o_value  + ITEM_VALUE[i];
                o_weight = o_weight + ITEM_WEIGHT[i];
                o_volume = o_volume + ITEM_VOLUME[i];
            end
        end
    end

endmodule

// File: rtl/knap_sweep.sv
// Exhaustive 2^13 knapsack sweep: counts feasible masks and tracks the best one.
// Define KNAP_FIRST_HIT_EN to stop the sweep at the first feasible mask.
module knap_sweep
    import knap_pkg::*;
#(
    parameter int MIN_VALUE  = 121,
    parameter int MAX_WEIGHT = 60,
    parameter int MAX_VOLUME = 60
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic [13:0] hit_count,
    output logic [12:0] best_mask,
    output logic [7:0]  best_value
);

    knap_state_t r_state;
    knap_state_t w_state_nxt;
    knap_mask_t  r_mask_p0;
    knap_mask_t  r_mask_p1;
    logic        r_vld_p1;
    logic [7:0]  r_val_p1;
    logic [7:0]  r_wt_p1;
    logic [7:0]  r_vol_p1;
    logic [7:0]  w_val;
    logic [7:0]  w_wt;
    logic [7:0]  w_vol;
    logic        w_feasible;
    logic        w_accept;
    logic        w_stop;
    logic        r_done;
    logic        r_found;
    logic [13:0] r_hits;
    knap_mask_t  r_best_mask;
    logic [7:0]  r_best_val;

    knap_totals u_totals (
        .i_mask   (r_mask_p0),
        .o_value  (w_val),
        .o_weight (w_wt),
        .o_volume (w_vol)
    );

    // Stage 1: totals of the issued mask
    always_ff @(posedge clk) begin
        r_mask_p1 <= r_mask_p0;
        r_val_p1  <= w_val;
        r_wt_p1   <= w_wt;
        r_vol_p1  <= w_vol;
    end

    // Stage 2: threshold test feeding the result registers
    assign w_feasible = (int'(r_val_p1) >= MIN_VALUE) &&
                        (int'(r_wt_p1)  <= MAX_WEIGHT) &&
                        (int'(r_vol_p1) <= MAX_VOLUME);

`ifdef KNAP_FIRST_HIT_EN
    // Once a hit is recorded, masks still in flight are discarded.
    assign w_accept = r_vld_p1 && w_feasible && !r_found;
    assign w_stop   = w_accept;
`else
    assign w_accept = r_vld_p1 && w_feasible;
    assign w_stop   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_SWEEP;
            ST_SWEEP: if (w_stop || (r_mask_p0 == LAST_MASK)) w_state_nxt = ST_DRAIN;
            ST_DRAIN: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask_p0   <= '0;
            r_vld_p1    <= 1'b0;
            r_done      <= 1'b0;
            r_found     <= 1'b0;
            r_hits      <= '0;
            r_best_mask <= '0;
            r_best_val  <= '0;
        end else begin
            r_vld_p1 <= (r_state == ST_SWEEP);
            r_done   <= (r_state == ST_DRAIN);
            if ((r_state == ST_IDLE) && start) begin
                r_mask_p0   <= '0;
                r_found     <= 1'b0;
                r_hits      <= '0;
                r_best_mask <= '0;
                r_best_val  <= '0;
            end else begin
                if (r_state == ST_SWEEP) begin
                    r_mask_p0 <= r_mask_p0 + 1'b1;
                end
                // Masks arrive in ascending order, so strict '>' keeps the lowest mask on ties.
                if (w_accept) begin
                    r_hits  <= r_hits + 1'b1;
                    r_found <= 1'b1;
                    if (!r_found || (r_val_p1 > r_best_val)) begin
                        r_best_mask <= r_mask_p1;
                        r_best_val  <= r_val_p1;
                    end
                end
            end
        end
    end

    assign busy       = (r_state != ST_IDLE);
    assign done       = r_done;
    assign found      = r_found;
    assign hit_count  = r_hits;
    assign best_mask  = r_best_mask;
    assign best_value = r_best_val;

endmodule

// File: tb/tb_knap_sweep.sv
// Bench for knap_sweep: four parameterisations swept together against a brute-force model.
module tb_knap_sweep;

    localparam int NI = 4;
    localparam int P_MIN [NI] = '{0, 161, 162, 121};
    localparam int P_WT  [NI] = '{255, 255, 255, 60};
    localparam int P_VOL [NI] = '{255, 255, 255, 60};
    localparam bit FIRST_HIT =
`ifdef KNAP_FIRST_HIT_EN
        1'b1;
`else
        1'b0;
`endif

    // Item A first; A maps to mask bit 12.
    localparam int TV [13] = '{4, 8, 0, 20, 10, 12, 18, 14, 6, 15, 30, 8, 16};
    localparam int TW [13] = '{28, 8, 27, 18, 27, 28, 6, 1, 20, 0, 5, 13, 8};
    localparam int TU [13] = '{27, 27, 4, 4, 0, 24, 4, 20, 12, 15, 5, 2, 9};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy       [NI];
    logic        done       [NI];
    logic        found      [NI];
    logic [13:0] hit_count  [NI];
    logic [12:0] best_mask  [NI];
    logic [7:0]  best_value [NI];

    int exp_found [NI];
    int exp_cnt   [NI];
    int exp_mask  [NI];
    int exp_val   [NI];
    int exp_done  [NI];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    knap_sweep #(.MIN_VALUE(0), .MAX_WEIGHT(255), .MAX_VOLUME(255)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy[0]), .done(done[0]),
        .found(found[0]), .hit_count(hit_count[0]), .best_mask(best_mask[0]),
        .best_value(best_value[0]));
    knap_sweep #(.MIN_VALUE(161), .MAX_WEIGHT(255), .MAX_VOLUME(255)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy[1]), .done(done[1]),
        .found(found[1]), .hit_count(hit_count[1]), .best_mask(best_mask[1]),
        .best_value(best_value[1]));
    knap_sweep #(.MIN_VALUE(162), .MAX_WEIGHT(255), .MAX_VOLUME(255)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy[2]), .done(done[2]),
        .found(found[2]), .hit_count(hit_count[2]), .best_mask(best_mask[2]),
        .best_value(best_value[2]));
    knap_sweep u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy[3]), .done(done[3]),
        .found(found[3]), .hit_count(hit_count[3]), .best_mask(best_mask[3]),
        .best_value(best_value[3]));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Brute force over all selections; ascending order makes the first max the lowest mask.
    task automatic build_model();
        int v, w, u, cnt, bm, bv, fm;
        bit feas;
        for (int k = 0; k < NI; k++) begin
            cnt = 0; bm = 0; bv = 0; fm = 0;
            for (int m = 0; m < 8192; m++) begin
                v = 0; w = 0; u = 0;
                for (int i = 0; i < 13; i++) begin
                    if (m[12-i]) begin
                        v += TV[i]; w += TW[i]; u += TU[i];
                    end
                end
                feas = (v >= P_MIN[k]) && (w <= P_WT[k]) && (u <= P_VOL[k]);
                if (feas && !(FIRST_HIT && cnt > 0)) begin
                    if (cnt == 0 || v > bv) begin
                        bm = m; bv = v;
                    end
                    if (cnt == 0) fm = m;
                    cnt++;
                end
            end
            exp_cnt[k]   = cnt;
            exp_found[k] = (cnt > 0) ? 1 : 0;
            exp_mask[k]  = bm;
            exp_val[k]   = bv;
            exp_done[k]  = (FIRST_HIT && cnt > 0) ? fm + 3 : 8193;
        end
    endtask

    task automatic check_results(input int k, input string when);
        check_val($sformatf("inst%0d %s found", k, when), 32'(found[k]), exp_found[k]);
        check_val($sformatf("inst%0d %s hit_count", k, when), 32'(hit_count[k]), exp_cnt[k]);
        check_val($sformatf("inst%0d %s best_mask", k, when), 32'(best_mask[k]), exp_mask[k]);
        check_val($sformatf("inst%0d %s best_value", k, when), 32'(best_value[k]), exp_val[k]);
    endtask

    task automatic check_all_zero(input string when);
        for (int k = 0; k < NI; k++) begin
            check_val($sformatf("inst%0d %s busy", k, when), 32'(busy[k]), 0);
            check_val($sformatf("inst%0d %s done", k, when), 32'(done[k]), 0);
            check_val($sformatf("inst%0d %s found", k, when), 32'(found[k]), 0);
            check_val($sformatf("inst%0d %s hit_count", k, when), 32'(hit_count[k]), 0);
            check_val($sformatf("inst%0d %s best_mask", k, when), 32'(best_mask[k]), 0);
            check_val($sformatf("inst%0d %s best_value", k, when), 32'(best_value[k]), 0);
        end
    endtask

    // Caller raises start before the accepting edge; c counts edges after that edge.
    task automatic run_sweep(input bit chain_next);
        int c_end;
        int done_cnt [NI];
        bit all_busy;
        c_end = 0;
        for (int k = 0; k < NI; k++) begin
            done_cnt[k] = 0;
            if (exp_done[k] > c_end) c_end = exp_done[k];
        end
        @(posedge clk);
        for (int c = 0; c <= c_end; c++) begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                if (c == 0) check_val($sformatf("inst%0d busy after accept", k), 32'(busy[k]), 1);
                if (done[k]) begin
                    done_cnt[k]++;
                    if (done_cnt[k] == 1) begin
                        check_val($sformatf("inst%0d done latency", k), c, exp_done[k]);
                        check_val($sformatf("inst%0d busy at done", k), 32'(busy[k]), 0);
                        check_results(k, "at done");
                    end
                end
            end
            all_busy = 1'b1;
            for (int k = 0; k < NI; k++) if (!busy[k]) all_busy = 1'b0;
            start = all_busy && ($urandom_range(0, 15) == 0);
        end
        for (int k = 0; k < NI; k++) begin
            check_val($sformatf("inst%0d done pulses", k), done_cnt[k], 1);
            check_results(k, "held");
        end
        start = chain_next;
    endtask

    initial begin
        int abort_at;
        bit seen_done [NI];
        build_model();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        @(negedge clk);
        start = 1'b1;
        run_sweep(1'b1);
        run_sweep(1'b0);

        // Abort a sweep part-way with an asynchronous reset.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        abort_at = $urandom_range(3995, 4005);
        repeat (abort_at) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < NI; k++) seen_done[k] = 1'b0;
        repeat (20) begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) if (done[k] || busy[k]) seen_done[k] = 1'b1;
        end
        for (int k = 0; k < NI; k++)
            check_val($sformatf("inst%0d idle after abort", k), 32'(seen_done[k]), 0);

        @(negedge clk);
        start = 1'b1;
        run_sweep(1'b0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
